// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: drives the instruction-memory port from the fetch PC,
// steps or redirects that PC, and holds one instruction for decode.
module fetch_ctrl #(
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] fet_pc_i,
   output logic        fet_en_o,
   output logic        fet_pc_update_o,
   output logic [31:0] fet_pc_redir_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        ex_redir_i,
   input  logic [31:0] ex_redir_pc_i,
   input  logic        trap_i,
   input  logic        dec_stall_i,
   output logic        ins_valid_o,
   output logic [31:0] ins_o,
   output logic [31:0] ins_pc_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_FLUSH
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_ins_valid;
   logic [31:0] r_ins;
   logic [31:0] r_ins_pc;

   logic        w_active;
   logic        w_redir;
   logic        w_free;
   logic        w_accept;
   logic        w_capture;
   logic        w_req;
   logic        w_fet_en;
   logic        w_pc_update;
   logic [31:0] w_redir_pc;

   // Redirects are ignored in IDLE, so everything below is gated by w_active.
   assign w_active = (r_state != S_IDLE);
   assign w_redir  = w_active & (trap_i | ex_redir_i);
   assign w_free   = ~r_ins_valid | ~dec_stall_i;
   assign w_accept = r_ins_valid & ~dec_stall_i;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_capture   = 1'b0;
      w_fet_en    = 1'b0;
      w_pc_update = 1'b0;
      w_redir_pc  = 32'h0;

      case (r_state)
         S_IDLE:  w_state_nxt = S_REQ;
         S_REQ: begin
            w_req = w_free & ~w_redir;
            if (w_req && imem_gnt_i) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid_i && !w_redir) begin
               w_capture   = 1'b1;
               w_fet_en    = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_FLUSH: begin
            if (imem_rvalid_i) begin
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // A redirect overrides everything; FLUSH only while a response is still owed,
      // so a response landing in the redirect cycle leaves nothing outstanding.
      if (w_redir) begin
         w_fet_en    = 1'b1;
         w_pc_update = 1'b1;
         w_redir_pc  = trap_i ? TRAP_VEC : ex_redir_pc_i;
         if ((r_state == S_WAIT || r_state == S_FLUSH) && !imem_rvalid_i) begin
            w_state_nxt = S_FLUSH;
         end else begin
            w_state_nxt = S_REQ;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The instruction slot is part of the visible reset state, so it is reset too.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ins_valid <= 1'b0;
         r_ins       <= 32'h0;
         r_ins_pc    <= 32'h0;
      end else if (w_redir) begin
         r_ins_valid <= 1'b0;
      end else if (w_capture) begin
         r_ins_valid <= 1'b1;
         r_ins       <= imem_rdata_i;
         r_ins_pc    <= fet_pc_i;
      end else if (w_accept) begin
         r_ins_valid <= 1'b0;
      end
   end

   assign imem_req_o      = w_req;
   assign imem_addr_o     = w_active ? fet_pc_i : 32'h0;
   assign fet_en_o        = w_fet_en;
   assign fet_pc_update_o = w_pc_update;
   assign fet_pc_redir_o  = w_redir_pc;
   assign ins_valid_o     = r_ins_valid;
   assign ins_o           = r_ins;
   assign ins_pc_o        = r_ins_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a PC register and memory environment plus a
// transaction-level reference of what the controller must expose each cycle.
module tb_fetch_ctrl;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] fet_pc_i;
   logic        fet_en_o;
   logic        fet_pc_update_o;
   logic [31:0] fet_pc_redir_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        ex_redir_i;
   logic [31:0] ex_redir_pc_i;
   logic        trap_i;
   logic        dec_stall_i;
   logic        ins_valid_o;
   logic [31:0] ins_o;
   logic [31:0] ins_pc_o;

   fetch_ctrl #(.TRAP_VEC(TRAP_VEC)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .fet_pc_i(fet_pc_i),
      .fet_en_o(fet_en_o), .fet_pc_update_o(fet_pc_update_o), .fet_pc_redir_o(fet_pc_redir_o),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .ex_redir_i(ex_redir_i), .ex_redir_pc_i(ex_redir_pc_i), .trap_i(trap_i),
      .dec_stall_i(dec_stall_i), .ins_valid_o(ins_valid_o), .ins_o(ins_o), .ins_pc_o(ins_pc_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Environment and reference state
   logic [31:0] tb_pc;
   logic        m_busy, m_stale;
   int          m_cnt;
   logic [31:0] m_addr;
   logic        slot_v;
   logic [31:0] slot_d, slot_pc;
   int          cyc, gnt_pct, dly_fix, idle_cnt, n_en;
   logic        s_req, s_en, s_upd, s_valid;
   logic [31:0] s_addr, s_redir, s_ins, s_ins_pc;
   int          en_q[$];
   logic [31:0] ipc_q[$];

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic env_reset();
      tb_pc = 0; m_busy = 0; m_stale = 0; m_cnt = 0; m_addr = 0;
      slot_v = 0; slot_d = 0; slot_pc = 0; idle_cnt = 0;
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_en"}, fet_en_o, 0);
      check({tag, "_upd"}, fet_pc_update_o, 0);
      check({tag, "_redir"}, fet_pc_redir_o, 0);
      check({tag, "_req"}, imem_req_o, 0);
      check({tag, "_addr"}, imem_addr_o, 0);
      check({tag, "_valid"}, ins_valid_o, 0);
      check({tag, "_ins"}, ins_o, 0);
      check({tag, "_ipc"}, ins_pc_o, 0);
   endtask

   // One clock cycle: drive memory-side inputs, check at the falling edge, then
   // advance the environment and reference at the rising edge.
   task automatic step();
      logic act, rd, cap, exp_req;
      logic [31:0] tgt;
      imem_gnt_i    = ($urandom_range(99) < gnt_pct);
      imem_rvalid_i = m_busy && (m_cnt == 0);
      imem_rdata_i  = imem_rvalid_i ? mem_f(m_addr) : $urandom();
      fet_pc_i      = tb_pc;
      @(negedge clk_i);
      act     = (cyc >= 1);
      rd      = act && (trap_i || ex_redir_i);
      tgt     = !rd ? 32'h0 : (trap_i ? TRAP_VEC : ex_redir_pc_i);
      cap     = act && imem_rvalid_i && !m_stale && !rd;
      exp_req = act && !m_busy && !rd && (!slot_v || !dec_stall_i);
      check("redir_pc", fet_pc_redir_o, tgt);
      check("pc_update", fet_pc_update_o, rd);
      check("fet_en", fet_en_o, rd | cap);
      check("imem_req", imem_req_o, exp_req);
      check("imem_addr", imem_addr_o, act ? tb_pc : 32'h0);
      check("ins_valid", ins_valid_o, slot_v);
      if (slot_v) begin
         check("ins", ins_o, slot_d);
         check("ins_pc", ins_pc_o, slot_pc);
      end
      s_req = imem_req_o; s_addr = imem_addr_o; s_en = fet_en_o; s_upd = fet_pc_update_o;
      s_redir = fet_pc_redir_o; s_valid = ins_valid_o; s_ins = ins_o; s_ins_pc = ins_pc_o;
      if (s_en) en_q.push_back(cyc);
      if (s_valid) ipc_q.push_back(s_ins_pc);
      @(posedge clk_i);
      if (m_busy) begin
         if (imem_rvalid_i) m_busy = 0;
         else m_cnt--;
      end
      if (s_req && imem_gnt_i) begin
         m_busy = 1; m_addr = tb_pc; m_stale = 0;
         m_cnt  = ((dly_fix > 0) ? dly_fix : int'($urandom_range(3, 1))) - 1;
      end
      if (rd && m_busy) m_stale = 1;
      if (rd) slot_v = 0;
      else if (cap) begin
         slot_v = 1; slot_pc = tb_pc; slot_d = mem_f(tb_pc);
      end else if (slot_v && !dec_stall_i) slot_v = 0;
      if (s_en) tb_pc = s_upd ? s_redir : tb_pc + 32'd4;
      if (s_en) begin idle_cnt = 0; n_en++; end
      else idle_cnt++;
      #1;
      cyc++;
   endtask

   task automatic wait_req(input string tag, input logic [31:0] exp_addr);
      int k = 0;
      do begin step(); k++; end while (!s_req && k < 20);
      check({tag, "_seen"}, s_req, 1);
      check({tag, "_addr"}, s_addr, exp_addr);
   endtask

   initial begin
      logic [31:0] held;
      int k;
      rst_ni = 0; fet_pc_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
      ex_redir_i = 0; ex_redir_pc_i = 0; trap_i = 0; dec_stall_i = 0;
      gnt_pct = 100; dly_fix = 1; n_en = 0;
      env_reset();
      repeat (2) @(posedge clk_i);
      #1;
      chk_zero("reset");
      rst_ni = 1; cyc = 0;

      // Straight-line fetch at full rate
      en_q.delete(); ipc_q.delete();
      repeat (8) step();
      check("seq_ipc0", ipc_q[0], 32'h0);
      check("seq_ipc1", ipc_q[1], 32'h4);
      check("seq_ipc2", ipc_q[2], 32'h8);
      check("seq_en0", en_q[0], 2);
      check("seq_en1", en_q[1], 4);
      check("seq_en2", en_q[2], 6);

      // Decode stall with a full slot blocks requests
      dec_stall_i = 1;
      k = 0;
      while (!(slot_v && !m_busy) && k < 10) begin step(); k++; end
      check("stall_setup", slot_v && !m_busy, 1);
      held = mem_f(slot_pc);
      repeat (5) begin
         step();
         check("stall_req", s_req, 0);
         check("stall_ins", s_ins, held);
      end
      dly_fix = 3;
      dec_stall_i = 0;
      step();
      check("unstall_req", s_req, 1);

      // Branch in WAIT with the response two cycles later
      ex_redir_i = 1; ex_redir_pc_i = 32'h40;
      step();
      check("br_upd", s_upd, 1);
      check("br_target", s_redir, 32'h40);
      ex_redir_i = 0;
      wait_req("br_req", 32'h40);
      k = 0;
      do begin step(); k++; end while (!s_valid && k < 20);
      check("br_ipc", s_ins_pc, 32'h40);
      check("br_ins", s_ins, mem_f(32'h40));

      // Trap beats a simultaneous branch
      dly_fix = 1;
      trap_i = 1; ex_redir_i = 1; ex_redir_pc_i = 32'h80;
      step();
      check("trap_target", s_redir, TRAP_VEC);
      check("trap_upd", s_upd, 1);
      trap_i = 0; ex_redir_i = 0;
      wait_req("trap_req", TRAP_VEC);

      // Redirect coinciding with the response: dropped, no FLUSH
      ex_redir_i = 1; ex_redir_pc_i = 32'h200;
      step();
      ex_redir_i = 0;
      step();
      check("drop_valid", s_valid, 0);
      check("drop_req", s_req, 1);
      check("drop_addr", s_addr, 32'h200);

      // Reset in the middle of WAIT
      dly_fix = 3;
      wait_req("rst_pre", 32'h204);
      step();
      rst_ni = 0;
      #1;
      chk_zero("rst_mid");
      env_reset();
      @(posedge clk_i);
      #1;
      rst_ni = 1; cyc = 0;
      ex_redir_i = 1; ex_redir_pc_i = 32'h300;
      step();
      check("idle_req", s_req, 0);
      check("idle_en", s_en, 0);
      check("idle_redir", s_redir, 0);
      ex_redir_i = 0;
      step();
      check("restart_req", s_req, 1);
      check("restart_addr", s_addr, 32'h0);

      // Randomized traffic against the reference
      gnt_pct = 70; dly_fix = 0; n_en = 0;
      repeat (3000) begin
         dec_stall_i   = ($urandom_range(99) < 30);
         ex_redir_i    = ($urandom_range(99) < 5);
         trap_i        = ($urandom_range(99) < 2);
         ex_redir_pc_i = $urandom() & 32'hFFFF_FFFC;
         step();
         if (idle_cnt > 100) begin
            check("liveness", idle_cnt, 0);
            idle_cnt = 0;
         end
      end
      check("progress", n_en > 300, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the rv32i fetch PC register and the instruction-memory port. It issues one instruction-memory request at a time at the current fetch PC. It drives the fetch enable/update controls so the PC advances by 4 per returned instruction or loads a redirect target. It buffers one instruction toward decode and squashes responses made stale by branches or traps.

## Interface
Parameters:
- TRAP_VEC, 32'h0000_0100, trap handler address loaded on trap_i.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- fet_pc_i  in  32  current PC from the fetch PC register.
- fet_en_o  out  1  fetch enable; PC advances by 4, or loads the target when update is set.
- fet_pc_update_o  out  1  load fet_pc_redir_o into the fetch PC.
- fet_pc_redir_o  out  32  redirect target.
- imem_req_o  out  1  instruction-memory request.
- imem_addr_o  out  32  request address, equal to fet_pc_i.
- imem_gnt_i  in  1  request accepted when imem_req_o & imem_gnt_i.
- imem_rvalid_i  in  1  response valid; at least 1 cycle after grant.
- imem_rdata_i  in  32  response instruction.
- ex_redir_i  in  1  branch/jump taken (1-cycle pulse).
- ex_redir_pc_i  in  32  branch/jump target.
- trap_i  in  1  trap/exception redirect (1-cycle pulse).
- dec_stall_i  in  1  decode cannot accept this cycle.
- ins_valid_o  out  1  instruction slot full.
- ins_o  out  32  buffered instruction.
- ins_pc_o  out  32  PC of the buffered instruction.

## Operation
- States: IDLE, REQ, WAIT, FLUSH. Reset enters IDLE. IDLE goes to REQ after 1 cycle.
- Redirect: redir = trap_i | ex_redir_i. Trap has priority.
  - Target = TRAP_VEC if trap_i, else ex_redir_pc_i.
  - fet_pc_redir_o = target, combinational. It is 0 when redir = 0.
- Redirect cycle, any state except IDLE:
  - fet_en_o = 1 and fet_pc_update_o = 1.
  - ins_valid_o clears at the next edge.
  - Next state: FLUSH if in WAIT without imem_rvalid_i, or already in FLUSH. Otherwise REQ.
  - A response arriving in the redirect cycle is dropped.
- Redirect in IDLE is ignored.
- Slot free: free = ~ins_valid_o | ~dec_stall_i.
- REQ state:
  - imem_req_o = free & ~redir.
  - On req & gnt, go to WAIT.
- WAIT state, on imem_rvalid_i without redir:
  - Capture ins_o <= imem_rdata_i and ins_pc_o <= fet_pc_i; set ins_valid_o.
  - Drive fet_en_o = 1 with fet_pc_update_o = 0, so the PC becomes PC+4.
  - Go to REQ.
- FLUSH state: on imem_rvalid_i, discard the data, do not pulse fet_en_o, and go to REQ.
- Accept: decode takes the slot when ins_valid_o & ~dec_stall_i. The slot clears unless refilled that same cycle.
- Outstanding requests: at most one. Requests are gated on a free slot, so a response never finds the slot full.
- fet_en_o is high only in redirect cycles and in accepted-response cycles.

## Timing
- Reset values: state IDLE; ins_valid_o 0; ins_o 0; ins_pc_o 0. All combinational outputs are 0, because they are gated off in IDLE.
- Best-case throughput: 1 instruction per 2 cycles (REQ/grant, then WAIT/rvalid).
- Latency: grant in cycle N, rvalid in cycle N+1, so ins_valid_o goes high at edge N+2.
- The PC increment and the slot capture take effect on the same edge.
- A redirect takes effect on the next edge: the fetch PC equals the target, and the first request at the target can issue one cycle later.
- Reset deassertion mid-transaction: any outstanding memory response is the memory's responsibility. The controller restarts cleanly from IDLE.
- Simultaneous redirect with accept or rvalid: redirect wins; the slot ends empty and the response is dropped.
- Simultaneous accept with refill: ins_valid_o stays 1 and holds the new data.

## Test plan
- Reset release, fet_pc_i = 0, gnt always 1, rvalid 1 cycle after grant, stall 0 -> requests at 0, 4, 8; ins_pc_o sequence 0, 4, 8; fet_en_o pulses every 2nd cycle.
- dec_stall_i held high for 5 cycles with the slot full -> imem_req_o stays 0 and ins_o is stable. Releasing the stall -> request issues in the same cycle.
- ex_redir_i with target 0x40 while in WAIT, rvalid 2 cycles later -> FLUSH; the stale data never appears; the next request address is 0x40 and ins_pc_o = 0x40.
- trap_i and ex_redir_i in the same cycle, ex_redir_pc_i = 0x80 -> fet_pc_redir_o = TRAP_VEC (0x100), fet_pc_update_o = 1.
- Redirect in the same cycle as rvalid in WAIT -> the response is dropped, ins_valid_o = 0, next state REQ, no FLUSH.
- rst_ni asserted mid-WAIT -> all outputs 0 immediately, without waiting for a clock edge; after release, IDLE then REQ.
